// File: rtl/bullet_hit_resolver.sv
// Per-tick collision pass: snapshots bullets/enemies/player, scans PB x enemy then EB x player, publishes survivors.
// Optional feature macro: BULLET_OFFSCREEN_CULL_EN (bullets outside the visible area are cleared while scanned).
module bullet_hit_resolver #(
  parameter int MAX_ENEMY         = 15,
  parameter int MAX_ENEMY_BULLET  = 31,
  parameter int MAX_PLAYER_BULLET = 15,
  parameter int ENEMY_W           = 32,
  parameter int ENEMY_H           = 24,
  parameter int PLAYER_W          = 24,
  parameter int PLAYER_H          = 24,
  parameter int BULLET_W          = 4,
  parameter int BULLET_H          = 8,
  parameter int SCREEN_W          = 640,
  parameter int SCREEN_H          = 480,
  parameter int KW                = $clog2(MAX_ENEMY + 1)
) (
  input  logic                            i_Clk,
  input  logic                            i_Rst,
  input  logic                            i_fStart,
  input  logic [MAX_ENEMY-1:0]            i_EnemyState,
  input  logic [19*MAX_ENEMY-1:0]         i_EnemyPosition,
  input  logic                            i_PlayerState,
  input  logic [18:0]                     i_PlayerPosition,
  input  logic [MAX_ENEMY_BULLET-1:0]     i_EnemyBulletState,
  input  logic [19*MAX_ENEMY_BULLET-1:0]  i_EnemyBulletPosition,
  input  logic [MAX_PLAYER_BULLET-1:0]    i_PlayerBulletState,
  input  logic [19*MAX_PLAYER_BULLET-1:0] i_PlayerBulletPosition,
  output logic [MAX_ENEMY-1:0]            o_EnemyState,
  output logic [MAX_ENEMY_BULLET-1:0]     o_EnemyBulletState,
  output logic [MAX_PLAYER_BULLET-1:0]    o_PlayerBulletState,
  output logic                            o_PlayerHit,
  output logic [KW-1:0]                   o_KillCount,
  output logic                            o_Busy,
  output logic                            o_fDone,
  output logic [1:0]                      o_DbgState
);

  localparam int PI_W = $clog2(MAX_PLAYER_BULLET);
  localparam int EI_W = $clog2(MAX_ENEMY);
  localparam int BI_W = $clog2(MAX_ENEMY_BULLET);

  localparam logic [PI_W-1:0] P_LAST = PI_W'(MAX_PLAYER_BULLET - 1);
  localparam logic [EI_W-1:0] E_LAST = EI_W'(MAX_ENEMY - 1);
  localparam logic [BI_W-1:0] B_LAST = BI_W'(MAX_ENEMY_BULLET - 1);

  localparam logic [10:0] EN_W11 = 11'(ENEMY_W);
  localparam logic [9:0]  EN_H10 = 10'(ENEMY_H);
  localparam logic [10:0] PL_W11 = 11'(PLAYER_W);
  localparam logic [9:0]  PL_H10 = 10'(PLAYER_H);
  localparam logic [10:0] BU_W11 = 11'(BULLET_W);
  localparam logic [9:0]  BU_H10 = 10'(BULLET_H);

  typedef enum logic [1:0] {S_IDLE, S_SCAN_PB, S_SCAN_EB, S_DONE} state_t;

  state_t                            state_q;
  logic [PI_W-1:0]                   p_q;
  logic [EI_W-1:0]                   e_q;
  logic [BI_W-1:0]                   b_q;
  logic [MAX_ENEMY-1:0]              en_q, en_d;
  logic [19*MAX_ENEMY-1:0]           en_pos_q;
  logic                              pl_alive_q;
  logic [18:0]                       pl_pos_q;
  logic [MAX_ENEMY_BULLET-1:0]       eb_q, eb_d;
  logic [19*MAX_ENEMY_BULLET-1:0]    eb_pos_q;
  logic [MAX_PLAYER_BULLET-1:0]      pb_q, pb_d;
  logic [19*MAX_PLAYER_BULLET-1:0]   pb_pos_q;
  logic                              hit_q, hit_d;
  logic [KW-1:0]                     kill_q, kill_d;

  // Strict AABB test; operands widened by one bit so x+w / y+h never wrap.
  function automatic logic overlap(input logic [9:0] ax, input logic [8:0] ay,
                                   input logic [10:0] aw, input logic [9:0] ah,
                                   input logic [9:0] bx, input logic [8:0] by,
                                   input logic [10:0] bw, input logic [9:0] bh);
    logic [10:0] ax_e, bx_e;
    logic [9:0]  ay_e, by_e;
    ax_e = {1'b0, ax};
    bx_e = {1'b0, bx};
    ay_e = {1'b0, ay};
    by_e = {1'b0, by};
    overlap = (ax_e < bx_e + bw) && (bx_e < ax_e + aw) &&
              (ay_e < by_e + bh) && (by_e < ay_e + ah);
  endfunction

  logic [18:0] pb_pos, en_pos, eb_pos;
  logic        pb_hit, eb_hit, pb_cull, eb_cull;

  assign pb_pos = pb_pos_q[19*int'(p_q) +: 19];
  assign en_pos = en_pos_q[19*int'(e_q) +: 19];
  assign eb_pos = eb_pos_q[19*int'(b_q) +: 19];

  assign pb_hit = overlap(pb_pos[18:9], pb_pos[8:0], BU_W11, BU_H10,
                          en_pos[18:9], en_pos[8:0], EN_W11, EN_H10);
  assign eb_hit = overlap(eb_pos[18:9], eb_pos[8:0], BU_W11, BU_H10,
                          pl_pos_q[18:9], pl_pos_q[8:0], PL_W11, PL_H10);

`ifdef BULLET_OFFSCREEN_CULL_EN
  function automatic logic offscreen(input logic [18:0] pos);
    offscreen = ({1'b0, pos[18:9]} >= 11'(SCREEN_W)) || ({1'b0, pos[8:0]} >= 10'(SCREEN_H));
  endfunction
  assign pb_cull = offscreen(pb_pos);
  assign eb_cull = offscreen(eb_pos);
`else
  assign pb_cull = 1'b0;
  assign eb_cull = 1'b0;
`endif

  always_comb begin
    en_d   = en_q;
    pb_d   = pb_q;
    eb_d   = eb_q;
    hit_d  = hit_q;
    kill_d = kill_q;
    if (state_q == S_SCAN_PB && pb_q[p_q]) begin
      if (pb_cull) begin
        pb_d[p_q] = 1'b0;
      end else if (en_q[e_q] && pb_hit) begin
        pb_d[p_q] = 1'b0;
        en_d[e_q] = 1'b0;
        kill_d    = kill_q + KW'(1);
      end
    end
    if (state_q == S_SCAN_EB && eb_q[b_q]) begin
      if (eb_cull) begin
        eb_d[b_q] = 1'b0;
      end else if (pl_alive_q && eb_hit) begin
        eb_d[b_q] = 1'b0;
        hit_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q             <= S_IDLE;
      p_q                 <= '0;
      e_q                 <= '0;
      b_q                 <= '0;
      en_q                <= '0;
      en_pos_q            <= '0;
      pl_alive_q          <= 1'b0;
      pl_pos_q            <= '0;
      eb_q                <= '0;
      eb_pos_q            <= '0;
      pb_q                <= '0;
      pb_pos_q            <= '0;
      hit_q               <= 1'b0;
      kill_q              <= '0;
      o_EnemyState        <= '0;
      o_EnemyBulletState  <= '0;
      o_PlayerBulletState <= '0;
      o_PlayerHit         <= 1'b0;
      o_KillCount         <= '0;
      o_Busy              <= 1'b0;
      o_fDone             <= 1'b0;
    end else begin
      o_fDone <= 1'b0;
      en_q    <= en_d;
      pb_q    <= pb_d;
      eb_q    <= eb_d;
      hit_q   <= hit_d;
      kill_q  <= kill_d;
      case (state_q)
        S_IDLE: begin
          if (i_fStart) begin
            en_q       <= i_EnemyState;
            en_pos_q   <= i_EnemyPosition;
            pl_alive_q <= i_PlayerState;
            pl_pos_q   <= i_PlayerPosition;
            eb_q       <= i_EnemyBulletState;
            eb_pos_q   <= i_EnemyBulletPosition;
            pb_q       <= i_PlayerBulletState;
            pb_pos_q   <= i_PlayerBulletPosition;
            hit_q      <= 1'b0;
            kill_q     <= '0;
            p_q        <= '0;
            e_q        <= '0;
            b_q        <= '0;
            o_Busy     <= 1'b1;
            state_q    <= S_SCAN_PB;
          end
        end
        S_SCAN_PB: begin
          if (e_q == E_LAST) begin
            e_q <= '0;
            if (p_q == P_LAST) begin
              p_q     <= '0;
              state_q <= S_SCAN_EB;
            end else begin
              p_q <= p_q + PI_W'(1);
            end
          end else begin
            e_q <= e_q + EI_W'(1);
          end
        end
        S_SCAN_EB: begin
          if (b_q == B_LAST) begin
            // Publish including the last bullet's result computed this cycle.
            b_q                 <= '0;
            state_q             <= S_DONE;
            o_EnemyState        <= en_d;
            o_EnemyBulletState  <= eb_d;
            o_PlayerBulletState <= pb_d;
            o_PlayerHit         <= hit_d;
            o_KillCount         <= kill_d;
            o_fDone             <= 1'b1;
            o_Busy              <= 1'b0;
          end else begin
            b_q <= b_q + BI_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_DbgState = state_q;

endmodule

// File: doc/bullet_hit_resolver.md
# bullet_hit_resolver

Per-frame consumer of the bullet/enemy/player state produced by the bullet generator/mover. On a start pulse it snapshots all states and positions, scans player bullets against enemies and enemy bullets against the player, and publishes cleared bullet masks, enemy-kill mask, player-hit flag and kill count. It sits between the bullet update stage and the stage/score logic, one run per game tick.

## Interface

- MAX_ENEMY, 15, enemy slots
- MAX_ENEMY_BULLET, 31, enemy bullet slots
- MAX_PLAYER_BULLET, 15, player bullet slots
- ENEMY_W / ENEMY_H, 32 / 24, enemy hit box (px)
- PLAYER_W / PLAYER_H, 24 / 24, player hit box
- BULLET_W / BULLET_H, 4 / 8, hit box of every bullet
- SCREEN_W / SCREEN_H, 640 / 480, visible area
- KW = $clog2(MAX_ENEMY+1), derived, kill-count width

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  synchronous, active-high reset
- i_fStart  in  1  one-cycle pulse; begin a resolve pass
- i_EnemyState  in  MAX_ENEMY  1 = enemy alive
- i_EnemyPosition  in  19 x MAX_ENEMY  [18:9] x, [8:0] y, top-left
- i_PlayerState  in  1  1 = player alive
- i_PlayerPosition  in  19  player top-left
- i_EnemyBulletState / i_EnemyBulletPosition  in  MAX_ENEMY_BULLET / 19 x MAX_ENEMY_BULLET
- i_PlayerBulletState / i_PlayerBulletPosition  in  MAX_PLAYER_BULLET / 19 x MAX_PLAYER_BULLET
- o_EnemyState  out  MAX_ENEMY  surviving enemies
- o_EnemyBulletState  out  MAX_ENEMY_BULLET  surviving enemy bullets
- o_PlayerBulletState  out  MAX_PLAYER_BULLET  surviving player bullets
- o_PlayerHit  out  1  player struck this pass
- o_KillCount  out  KW  enemies killed this pass
- o_Busy  out  1  pass in progress
- o_fDone  out  1  one-cycle pulse, outputs just updated

## Operation

- FSM: IDLE -> SCAN_PB -> SCAN_EB -> DONE -> IDLE.
- IDLE: i_fStart=1 snapshots every input into working registers; go SCAN_PB. i_fStart outside IDLE ignored.
- SCAN_PB: indices (p,e), e inner, one pair per cycle, exactly MAX_PLAYER_BULLET*MAX_ENEMY cycles. Pair tests only if bullet p active, not yet consumed, enemy e alive in working copy. On overlap: clear bullet p, clear enemy e, KillCount+1. A bullet kills at most one enemy (lowest e); a killed enemy cannot be hit by later bullets.
- SCAN_EB: one enemy bullet per cycle, MAX_ENEMY_BULLET cycles. If bullet active, player alive and overlap: clear bullet, set PlayerHit. Every overlapping bullet is cleared; PlayerHit is sticky for the pass.
- Overlap (AABB, strict): ax < bx+bw and bx < ax+aw, same on y. Sums in 11-bit x / 10-bit y, no wrap.
- DONE: working copies copied to outputs on entry edge; o_fDone=1 for that cycle; outputs hold until next DONE.
- Inactive bullets never hit, are never revived; output state bits are only ever cleared relative to snapshot.

## Timing

- Start sampled at edge k: o_Busy=1 from k+1; SCAN_PB cycles k+1..k+MAX_PLAYER_BULLET*MAX_ENEMY; SCAN_EB next MAX_ENEMY_BULLET cycles; o_fDone in cycle k+1+P*E+B (defaults: k+257); o_Busy=0 in DONE.
- Latency fixed, independent of data or early hits.
- Start may be re-issued in the cycle after DONE.
- Reset (any state, incl. mid-pass): FSM IDLE, pass aborted, all outputs 0 (all state masks 0, o_PlayerHit 0, o_KillCount 0, o_Busy 0, o_fDone 0).

## Configuration

- BULLET_OFFSCREEN_CULL_EN defined: during each scan step the bullet is also cleared if x >= SCREEN_W or y >= SCREEN_H (catches upward wrap to 511); culled bullets take no part in hits, no kill/hit credit.
- Undefined: only collisions clear bullets; off-screen bullets pass through unchanged.

## Test plan

- Reset, then pulse start with all states 0 -> o_fDone at k+257, all outputs 0, KillCount 0.
- PB0 at (100,100), enemy 3 alive at (90,90) -> o_EnemyState bit3=0, PB bit0=0, KillCount=1.
- PB0 and PB1 both overlap enemy 0 only -> enemy 0 cleared, PB0 cleared, PB1 survives, KillCount=1.
- Player alive at (300,400); EB2, EB7 overlap; EB5 at (0,0) -> EB2/EB7 cleared, EB5 kept, o_PlayerHit=1; player dead -> all kept, o_PlayerHit=0.
- PB4 y=510 no overlap -> with BULLET_OFFSCREEN_CULL_EN cleared, without kept.
- Assert i_Rst at k+100 mid-pass -> next cycle IDLE, all outputs 0, no o_fDone; start pulses during busy ignored.
